pcs_link_ctrl: RTL and testbench
================================

Name: pcs_link_ctrl

Overview:
Link-bring-up controller and transmit gate for the 1000BASE-X PCS. It sequences PCS reset through mr_main_reset and waits for stable code-group sync from the synchroniser. Only then does it forward the MAC's TX_EN/TXD to the transmit ordered-set machine, always on whole-frame boundaries. On loss of sync it aborts any frame in flight and re-runs bring-up.

Parameters:
RST_CYCLES, 16, cycles mr_main_reset is held high in RST_HOLD (min 1)
SYNC_STABLE, 8, consecutive cycles code_sync_status must be high before link-up (min 1)
MAX_FAILS, 4, consecutive link failures that force a full PCS re-reset (min 1)

Ports:
clock  input  1  single clock (GTX_CLK domain)
reset  input  1  asynchronous, active-low reset
mac_tx_en  input  1  MAC transmit enable
mac_txd  input  8  MAC transmit data
code_sync_status  input  1  synchroniser sync indication (1 = OK)
TX_EN  output  1  gated enable to transmit_ordered_set
TXD  output  8  gated data to transmit_ordered_set
mr_main_reset  output  1  PCS management reset to receptor (active-high)
link_up  output  1  high while in LINK_UP
tx_abort  output  1  one-cycle pulse when an in-flight frame is truncated

Behaviour:
- Reset (reset=0, async): state=RST_HOLD, mr_main_reset=1, TX_EN=0, TXD=8'h00, link_up=0, tx_abort=0; all counters 0.
- All outputs are registered. TX_EN/TXD follow mac_tx_en/mac_txd with 1-cycle latency when forwarding.
- RST_HOLD: mr_main_reset=1; timer counts 0..RST_CYCLES-1. On the last count go to WAIT_SYNC; mr_main_reset=0 from the first WAIT_SYNC cycle. Clear fail_cnt on entry.
- WAIT_SYNC: stable counter increments while code_sync_status=1 and clears to 0 on any 0. When it reaches SYNC_STABLE go to LINK_UP, so link_up rises SYNC_STABLE+1 cycles after sync first holds. No forwarding here: TX_EN=0, TXD=0.
- LINK_UP: link_up=1.
  - Frame gate: a frame is admitted only if mac_tx_en rises (0->1 edge) while in LINK_UP.
  - If mac_tx_en is already 1 on entry to LINK_UP, that frame is suppressed until mac_tx_en returns to 0. No truncated frame heads are ever sent.
  - While admitted, TX_EN/TXD mirror the MAC with 1-cycle delay. When mac_tx_en falls, the frame is complete.
  - A full admitted frame clears fail_cnt.
- Sync loss (code_sync_status=0 in LINK_UP): next cycle TX_EN=0, TXD=0, link_up=0. If a frame was being forwarded, tx_abort=1 for exactly that cycle. fail_cnt increments (saturating at MAX_FAILS). Next state:
  - RST_HOLD if the new fail_cnt == MAX_FAILS;
  - otherwise WAIT_SYNC, with the stable counter cleared.
- Sync loss in the same cycle as a mac_tx_en rise: the loss wins; the frame is not admitted and there is no tx_abort.
- Sync loss on the cycle mac_tx_en falls: the frame is counted complete; no abort.
- Async reset mid-frame: TX_EN drops immediately (combinationally via the flop reset); no tx_abort pulse.
- RST_CYCLES/SYNC_STABLE timers are sized $clog2(param+1) bits and never wrap.

Optional Feature:
PCS_LINK_STATS_EN. When defined, two extra outputs exist:
- link_fail_total [7:0]: increments on every LINK_UP->fail transition.
- abort_total [7:0]: increments on every tx_abort pulse.

Both counters saturate at 8'hFF and reset to 0 only on async reset, not on RST_HOLD. When undefined, these ports and their registers are absent and all other behaviour is identical.

Test Plan:
- Reset release, code_sync_status=1 constant, defaults: mr_main_reset=1 for 16 cycles, then 0. link_up rises 9 cycles after entering WAIT_SYNC. TX_EN=0 throughout.
- Sync glitch in WAIT_SYNC: sync high 5 cycles, low 1, high 8 -> link_up only after the final 8-cycle run completes.
- Clean frame in LINK_UP: mac_tx_en high 10 cycles, TXD=8'h55..8'h5E -> TX_EN high 10 cycles delayed by 1, TXD matches byte-for-byte, tx_abort never asserted.
- MAC already transmitting at link-up: mac_tx_en=1 before LINK_UP -> TX_EN stays 0 until mac_tx_en falls. The next rising frame is forwarded.
- Sync drop mid-frame at byte 4 -> TX_EN=0 and tx_abort=1 for 1 cycle, link_up=0, state returns to WAIT_SYNC with mr_main_reset=0. With PCS_LINK_STATS_EN, abort_total=1 and link_fail_total=1.
- Four consecutive sync losses with no completed frame (MAX_FAILS=4) -> on the 4th, mr_main_reset=1 again for 16 cycles. A subsequent clean frame clears fail_cnt.

Source files
------------

// File: rtl/pcs_link_ctrl.sv
// 1000BASE-X PCS link bring-up sequencer and whole-frame transmit gate.
// Optional PCS_LINK_STATS_EN adds saturating link-fail and abort totals.
module pcs_link_ctrl #(
   parameter int RST_CYCLES  = 16,
   parameter int SYNC_STABLE = 8,
   parameter int MAX_FAILS   = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       mac_tx_en,
   input  logic [7:0] mac_txd,
   input  logic       code_sync_status,
   output logic       TX_EN,
   output logic [7:0] TXD,
   output logic       mr_main_reset,
   output logic       link_up,
   output logic       tx_abort
`ifdef PCS_LINK_STATS_EN
   ,
   output logic [7:0] link_fail_total,
   output logic [7:0] abort_total
`endif
);

   localparam int TW = $clog2(RST_CYCLES + 1);
   localparam int SW = $clog2(SYNC_STABLE + 1);
   localparam int FW = $clog2(MAX_FAILS + 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(RST_CYCLES - 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(SYNC_STABLE);
   localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);

   typedef enum logic [1:0] {
      RST_HOLD,
      WAIT_SYNC,
      LINK_UP
   } state_t;

   state_t        r_state, w_state;
   logic [TW-1:0] r_tmr, w_tmr;
   logic [SW-1:0] r_stab, w_stab;
   logic [FW-1:0] r_fail, w_fail;
   logic [FW-1:0] w_fail_base, w_fail_inc;
   logic          r_prev_en;
   logic          r_adm, w_adm;
   logic          r_tx_en, w_tx_en;
   logic [7:0]    r_txd, w_txd;
   logic          r_mr, w_mr;
   logic          r_link, w_link;
   logic          r_abort, w_abort;
   logic          w_rise, w_done;

   always_comb begin
      w_state     = r_state;
      w_tmr       = r_tmr;
      w_stab      = r_stab;
      w_fail      = r_fail;
      w_adm       = 1'b0;
      w_tx_en     = 1'b0;
      w_txd       = 8'h00;
      w_mr        = 1'b0;
      w_link      = 1'b0;
      w_abort     = 1'b0;
      w_rise      = mac_tx_en & ~r_prev_en;
      w_done      = r_adm & ~mac_tx_en;
      // a frame ending on the loss cycle counts as complete first
      w_fail_base = w_done ? '0 : r_fail;
      w_fail_inc  = (w_fail_base == FAIL_MAX) ? FAIL_MAX
                                              : w_fail_base + FW'(1);
      unique case (r_state)
         RST_HOLD: begin
            w_mr = 1'b1;
            if (r_tmr == TMR_LAST) begin
               w_state = WAIT_SYNC;
               w_tmr   = '0;
               w_stab  = '0;
               w_mr    = 1'b0;
            end else begin
               w_tmr = r_tmr + TW'(1);
            end
         end
         WAIT_SYNC: begin
            if (r_stab == STAB_MAX) begin
               w_state = LINK_UP;
               w_stab  = '0;
               w_link  = 1'b1;
            end else if (code_sync_status) begin
               w_stab = r_stab + SW'(1);
            end else begin
               w_stab = '0;
            end
         end
         LINK_UP: begin
            if (!code_sync_status) begin
               w_abort = r_adm & mac_tx_en;
               w_stab  = '0;
               if (w_fail_inc == FAIL_MAX) begin
                  w_state = RST_HOLD;
                  w_tmr   = '0;
                  w_fail  = '0;
                  w_mr    = 1'b1;
               end else begin
                  w_state = WAIT_SYNC;
                  w_fail  = w_fail_inc;
               end
            end else begin
               w_link  = 1'b1;
               // only a fresh rising edge opens a frame
               w_adm   = mac_tx_en & (r_adm | w_rise);
               w_tx_en = w_adm;
               w_txd   = w_adm ? mac_txd : 8'h00;
               if (w_done) w_fail = '0;
            end
         end
         default: begin
            w_state = RST_HOLD;
            w_tmr   = '0;
            w_mr    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= RST_HOLD;
         r_tmr     <= '0;
         r_stab    <= '0;
         r_fail    <= '0;
         r_prev_en <= 1'b0;
         r_adm     <= 1'b0;
         r_tx_en   <= 1'b0;
         r_txd     <= 8'h00;
         r_mr      <= 1'b1;
         r_link    <= 1'b0;
         r_abort   <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_tmr     <= w_tmr;
         r_stab    <= w_stab;
         r_fail    <= w_fail;
         r_prev_en <= mac_tx_en;
         r_adm     <= w_adm;
         r_tx_en   <= w_tx_en;
         r_txd     <= w_txd;
         r_mr      <= w_mr;
         r_link    <= w_link;
         r_abort   <= w_abort;
      end
   end

   assign TX_EN         = r_tx_en;
   assign TXD           = r_txd;
   assign mr_main_reset = r_mr;
   assign link_up       = r_link;
   assign tx_abort      = r_abort;

`ifdef PCS_LINK_STATS_EN
   logic [7:0] r_fail_tot;
   logic [7:0] r_abort_tot;

   // totals survive PCS re-reset; only the async reset clears them
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_fail_tot  <= 8'h00;
         r_abort_tot <= 8'h00;
      end else begin
         if (r_state == LINK_UP && !code_sync_status &&
             r_fail_tot != 8'hFF)
            r_fail_tot <= r_fail_tot + 8'd1;
         if (w_abort && r_abort_tot != 8'hFF)
            r_abort_tot <= r_abort_tot + 8'd1;
      end
   end

   assign link_fail_total = r_fail_tot;
   assign abort_total     = r_abort_tot;
`endif

endmodule

// File: tb/tb_pcs_link_ctrl.sv
// Bench for pcs_link_ctrl: bring-up timing, frame gating, sync loss.
// Forwarded bytes are checked against a scoreboard queue.
module tb_pcs_link_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       mac_tx_en = 1'b0;
   logic [7:0] mac_txd = 8'h00;
   logic       code_sync_status = 1'b0;
   logic       TX_EN;
   logic [7:0] TXD;
   logic       mr_main_reset;
   logic       link_up;
   logic       tx_abort;
`ifdef PCS_LINK_STATS_EN
   logic [7:0] link_fail_total;
   logic [7:0] abort_total;
`endif

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] b;

   pcs_link_ctrl dut (
      .clock(clock),
      .reset(reset),
      .mac_tx_en(mac_tx_en),
      .mac_txd(mac_txd),
      .code_sync_status(code_sync_status),
      .TX_EN(TX_EN),
      .TXD(TXD),
      .mr_main_reset(mr_main_reset),
      .link_up(link_up),
      .tx_abort(tx_abort)
`ifdef PCS_LINK_STATS_EN
      ,
      .link_fail_total(link_fail_total),
      .abort_total(abort_total)
`endif
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (TX_EN === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL txd_unexpected got %h required no frame", TXD);
         end else begin
            b = exp_q.pop_front();
            if (TXD !== b) begin
               errors++;
               $display("FAIL txd_data got %h required %h", TXD, b);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input logic s);
      mac_tx_en = 1'b0;
      mac_txd = 8'h00;
      code_sync_status = s;
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic wait_link(input int maxc);
      int n = 0;
      while (link_up !== 1'b1 && n < maxc) begin
         tick();
         n++;
      end
      checks++;
      if (link_up !== 1'b1) begin
         errors++;
         $display("FAIL wait_link got %b required 1 within %0d", link_up, maxc);
      end
   endtask

   task automatic test_reset();
      int n;
      int bad_tx;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      #2;
      checks++;
      if ({mr_main_reset, TX_EN, TXD, link_up, tx_abort} !== 12'b1_0_00000000_0_0) begin
         errors++;
         $display("FAIL reset_outputs got mr%b en%b txd%h lu%b ab%b required 1 0 00 0 0",
                  mr_main_reset, TX_EN, TXD, link_up, tx_abort);
      end
      code_sync_status = 1'b1;
      tick();
      reset = 1'b1;
      n = 0;
      bad_tx = 0;
      while (mr_main_reset === 1'b1 && n < 100) begin
         tick();
         n++;
         if (TX_EN !== 1'b0) bad_tx++;
      end
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL rst_hold_len got %0d required 16", n);
      end
      n = 0;
      while (link_up !== 1'b1 && n < 100) begin
         tick();
         n++;
         if (TX_EN !== 1'b0) bad_tx++;
      end
      checks++;
      if (n != 9) begin
         errors++;
         $display("FAIL link_latency got %0d required 9", n);
      end
      checks++;
      if (bad_tx != 0) begin
         errors++;
         $display("FAIL tx_en_bringup got %0d high cycles required 0", bad_tx);
      end
   endtask

   task automatic test_sync_glitch();
      int n = 0;
      do_reset(1'b0);
      while (mr_main_reset === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      code_sync_status = 1'b1;
      for (int i = 0; i < 14; i++) begin
         code_sync_status = (i == 5) ? 1'b0 : 1'b1;
         tick();
         checks++;
         if (link_up !== 1'b0) begin
            errors++;
            $display("FAIL glitch_early step %0d got %b required 0", i, link_up);
         end
      end
      code_sync_status = 1'b1;
      tick();
      checks++;
      if (link_up !== 1'b1) begin
         errors++;
         $display("FAIL glitch_link got %b required 1", link_up);
      end
   endtask

   task automatic send_frame(input logic [7:0] base, input int len);
      for (int i = 0; i < len; i++) begin
         mac_tx_en = 1'b1;
         mac_txd = base + 8'(i);
         exp_q.push_back(mac_txd);
         tick();
         checks++;
         if (TX_EN !== 1'b1 || tx_abort !== 1'b0) begin
            errors++;
            $display("FAIL frame_%h byte %0d got en%b ab%b required 1 0",
                     base, i, TX_EN, tx_abort);
         end
      end
      mac_tx_en = 1'b0;
      mac_txd = 8'h00;
      tick();
      checks++;
      if (TX_EN !== 1'b0 || TXD !== 8'h00) begin
         errors++;
         $display("FAIL frame_end_%h got en%b txd%h required 0 00", base, TX_EN, TXD);
      end
   endtask

   task automatic check_drained(input string name);
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain got %0d pending required 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_clean_frame();
      mac_tx_en = 1'b1;
      mac_txd = 8'h55;
      checks++;
      if (TX_EN !== 1'b0) begin
         errors++;
         $display("FAIL frame_latency got %b required 0", TX_EN);
      end
      send_frame(8'h55, 10);
      send_frame(8'hA0, 3);
      check_drained("clean");
   endtask

   task automatic test_mac_busy();
      do_reset(1'b1);
      mac_tx_en = 1'b1;
      mac_txd = 8'hAA;
      wait_link(60);
      for (int i = 0; i < 4; i++) begin
         mac_tx_en = (i < 3) ? 1'b1 : 1'b0;
         tick();
         checks++;
         if (TX_EN !== 1'b0) begin
            errors++;
            $display("FAIL busy_suppress step %0d got %b required 0", i, TX_EN);
         end
      end
      send_frame(8'hC0, 4);
      check_drained("busy");
   endtask

   task automatic test_sync_drop();
      for (int i = 0; i < 4; i++) begin
         mac_tx_en = 1'b1;
         mac_txd = 8'h10 + 8'(i);
         exp_q.push_back(mac_txd);
         tick();
      end
      mac_txd = 8'h14;
      code_sync_status = 1'b0;
      tick();
      checks++;
      if ({TX_EN, TXD, tx_abort, link_up, mr_main_reset} !== 12'b0_00000000_1_0_0) begin
         errors++;
         $display("FAIL drop_state got en%b txd%h ab%b lu%b mr%b required 0 00 1 0 0",
                  TX_EN, TXD, tx_abort, link_up, mr_main_reset);
      end
      code_sync_status = 1'b1;
      mac_tx_en = 1'b0;
      tick();
      checks++;
      if (tx_abort !== 1'b0 || mr_main_reset !== 1'b0) begin
         errors++;
         $display("FAIL drop_pulse got ab%b mr%b required 0 0", tx_abort, mr_main_reset);
      end
`ifdef PCS_LINK_STATS_EN
      checks++;
      if (abort_total !== 8'd1 || link_fail_total !== 8'd1) begin
         errors++;
         $display("FAIL drop_stats got ab%0d lf%0d required 1 1",
                  abort_total, link_fail_total);
      end
`endif
      check_drained("drop");
      wait_link(20);
   endtask

   task automatic lose_sync(input logic exp_mr, input int k);
      code_sync_status = 1'b0;
      tick();
      code_sync_status = 1'b1;
      checks++;
      if (link_up !== 1'b0 || mr_main_reset !== exp_mr) begin
         errors++;
         $display("FAIL loss_%0d got lu%b mr%b required 0 %b",
                  k, link_up, mr_main_reset, exp_mr);
      end
   endtask

   task automatic test_max_fails();
      int n = 0;
      do_reset(1'b1);
      wait_link(60);
      for (int k = 1; k <= 3; k++) begin
         lose_sync(1'b0, k);
         wait_link(20);
      end
      send_frame(8'hE0, 3);
      for (int k = 4; k <= 6; k++) begin
         lose_sync(1'b0, k);
         wait_link(20);
      end
      lose_sync(1'b1, 7);
      while (mr_main_reset === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL rereset_len got %0d required 16", n);
      end
      wait_link(20);
      check_drained("fails");
   endtask

   task automatic test_loss_edges();
      mac_tx_en = 1'b1;
      mac_txd = 8'h77;
      code_sync_status = 1'b0;
      tick();
      checks++;
      if (TX_EN !== 1'b0 || tx_abort !== 1'b0 || link_up !== 1'b0) begin
         errors++;
         $display("FAIL loss_on_rise got en%b ab%b lu%b required 0 0 0",
                  TX_EN, tx_abort, link_up);
      end
      code_sync_status = 1'b1;
      wait_link(20);
      tick();
      checks++;
      if (TX_EN !== 1'b0) begin
         errors++;
         $display("FAIL loss_rise_suppress got %b required 0", TX_EN);
      end
      mac_tx_en = 1'b0;
      tick();
      for (int i = 0; i < 2; i++) begin
         mac_tx_en = 1'b1;
         mac_txd = 8'h81 + 8'(i);
         exp_q.push_back(mac_txd);
         tick();
      end
      mac_tx_en = 1'b0;
      code_sync_status = 1'b0;
      tick();
      checks++;
      if (TX_EN !== 1'b0 || tx_abort !== 1'b0 || link_up !== 1'b0) begin
         errors++;
         $display("FAIL loss_on_fall got en%b ab%b lu%b required 0 0 0",
                  TX_EN, tx_abort, link_up);
      end
      code_sync_status = 1'b1;
      check_drained("edges");
      wait_link(20);
   endtask

   task automatic test_async_reset();
      mac_tx_en = 1'b1;
      mac_txd = 8'h3C;
      exp_q.push_back(mac_txd);
      tick();
      @(negedge clock);
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if ({TX_EN, TXD, tx_abort, link_up, mr_main_reset} !== 12'b0_00000000_0_0_1) begin
         errors++;
         $display("FAIL async_reset got en%b txd%h ab%b lu%b mr%b required 0 00 0 0 1",
                  TX_EN, TXD, tx_abort, link_up, mr_main_reset);
      end
      mac_tx_en = 1'b0;
      tick();
      checks++;
      if (exp_q.size() != 0 || tx_abort !== 1'b0) begin
         errors++;
         $display("FAIL async_drain got %0d pending ab%b required 0 0",
                  exp_q.size(), tx_abort);
      end
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_sync_glitch();
      test_clean_frame();
      test_mac_busy();
      test_sync_drop();
      test_max_fails();
      test_loss_edges();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
